// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types, shift and PC2 tables for the DES key schedule
package des_pkg;

    typedef logic [28:1] half_t;
    typedef logic [48:1] subkey_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMIT} state_t;

    // S(n) table indexed by round code n-1: bit set means a 2-bit shift, clear means 1 (rounds 1,2,9,16)
    localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

    localparam int PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit 1 is the leftmost FIPS bit, so a FIPS left rotation moves bits toward index 1.
    function automatic half_t rotl(input half_t h, input logic two);
        return two ? {h[2:1], h[28:3]} : {h[1], h[28:2]};
    endfunction

    function automatic half_t rotr(input half_t h, input logic two);
        return two ? {h[26:1], h[28:27]} : {h[27:1], h[28]};
    endfunction

endpackage

// File: rtl/des_pc1.sv
// rtl/des_pc1.sv - PC1 permutation: 64-bit key to C0/D0 halves
module des_pc1
    import des_pkg::*;
(
    input  logic [64:1] key_i,
    output half_t       c_o,
    output half_t       d_o
);

    localparam int PC1_C [1:28] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36
    };
    localparam int PC1_D [1:28] = '{
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 1; i <= 28; i++) begin : g_sel
        assign c_o[i] = key_i[PC1_C[i]];
        assign d_o[i] = key_i[PC1_D[i]];
    end

    // Parity bits never reach the key halves.
    logic unused_par;
    assign unused_par = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                          key_i[40], key_i[48], key_i[56], key_i[64]};

endmodule

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - PC2 selection: C/D halves to 48-bit round subkey
module des_pc2
    import des_pkg::*;
(
    input  half_t   c_i,
    input  half_t   d_i,
    output subkey_t subkey_o
);

    logic [56:1] cd;
    assign cd = {d_i, c_i};

    for (genvar i = 1; i <= 48; i++) begin : g_sel
        assign subkey_o[i] = cd[PC2_TBL[i]];
    end

    // PC2 drops eight of the 56 bits.
    logic unused_cd;
    assign unused_cd = ^{c_i[9], c_i[18], c_i[22], c_i[25],
                         d_i[7], d_i[10], d_i[15], d_i[26]};

endmodule

// File: rtl/des_subkey_sched.sv
// rtl/des_subkey_sched.sv - sequential DES key schedule streaming 16 subkeys
module des_subkey_sched
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [64:1] key,
    output logic        busy,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic [3:0]  subkey_round,
    output logic        done,
    output logic        key_parity_err
);

    state_t  state_q;
    half_t   c_q, d_q, c_nx, d_nx, pc1_c, pc1_d;
    logic    mode_q;
    logic [3:0] rnd_q, rnd_nx, skr_q;
    logic    busy_q, valid_q, done_q, perr_q;
    subkey_t sk_q, sk_nx;
    logic [8:1] byte_odd;
    logic    parity_err, xfer, last;

    des_pc1 u_pc1 (.key_i(key), .c_o(pc1_c), .d_o(pc1_d));
    des_pc2 u_pc2 (.c_i(c_nx), .d_i(d_nx), .subkey_o(sk_nx));

    for (genvar b = 1; b <= 8; b++) begin : g_par
        assign byte_odd[b] = ^key[8*b -: 8];
    end
    assign parity_err = ~&byte_odd;

    assign xfer = valid_q & subkey_ready;
    assign last = mode_q ? (rnd_q == 4'd0) : (rnd_q == 4'd15);

    // Decrypt starts from C16 = C0 and undoes the shift of the round just emitted.
    always_comb begin
        c_nx   = c_q;
        d_nx   = d_q;
        rnd_nx = rnd_q;
        if (state_q == ST_LOAD) begin
            if (!mode_q) begin
                c_nx = rotl(c_q, SHIFT_TWO[0]);
                d_nx = rotl(d_q, SHIFT_TWO[0]);
            end
        end else if (!mode_q) begin
            rnd_nx = rnd_q + 4'd1;
            c_nx   = rotl(c_q, SHIFT_TWO[rnd_nx]);
            d_nx   = rotl(d_q, SHIFT_TWO[rnd_nx]);
        end else begin
            rnd_nx = rnd_q - 4'd1;
            c_nx   = rotr(c_q, SHIFT_TWO[rnd_q]);
            d_nx   = rotr(d_q, SHIFT_TWO[rnd_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            rnd_q   <= 4'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            sk_q    <= '0;
            skr_q   <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    c_q     <= pc1_c;
                    d_q     <= pc1_d;
                    mode_q  <= decrypt;
                    rnd_q   <= decrypt ? 4'd15 : 4'd0;
                    perr_q  <= PARITY_CHECK ? parity_err : 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    c_q     <= c_nx;
                    d_q     <= d_nx;
                    sk_q    <= sk_nx;
                    skr_q   <= rnd_q;
                    valid_q <= 1'b1;
                    state_q <= ST_EMIT;
                end
                ST_EMIT: if (xfer) begin
                    if (last) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        c_q   <= c_nx;
                        d_q   <= d_nx;
                        rnd_q <= rnd_nx;
                        sk_q  <= sk_nx;
                        skr_q <= rnd_nx;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign subkey_valid   = valid_q;
    assign subkey         = sk_q;
    assign subkey_round   = skr_q;
    assign done           = done_q;
    assign key_parity_err = perr_q;

endmodule

// File: tb/tb_des_subkey_sched.sv
// tb/tb_des_subkey_sched.sv - self-checking bench for des_subkey_sched
module tb_des_subkey_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, decrypt, subkey_ready;
    logic [64:1] key;
    logic        busy, valid, done, perr;
    logic [48:1] subkey;
    logic [3:0]  rnd;
    logic        busy0, valid0, done0, perr0;
    logic [48:1] subkey0;
    logic [3:0]  rnd0;

    des_subkey_sched #(.PARITY_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
        .busy(busy), .subkey_valid(valid), .subkey_ready(subkey_ready),
        .subkey(subkey), .subkey_round(rnd), .done(done), .key_parity_err(perr)
    );

    des_subkey_sched #(.PARITY_CHECK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
        .busy(busy0), .subkey_valid(valid0), .subkey_ready(subkey_ready),
        .subkey(subkey0), .subkey_round(rnd0), .done(done0), .key_parity_err(perr0)
    );

    int checks = 0;
    int errors = 0;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [47:0] model_ks [16];
    logic [47:0] cap [16];

    typedef struct {
        logic [63:0] kh;
        bit          dec;
        int          idx;
        logic [47:0] exp;
    } vec_t;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_Z = 64'h0101010101010101;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [64:1] to_key(input logic [63:0] h);
        logic [64:1] k;
        for (int n = 1; n <= 64; n++) k[n] = h[64-n];
        return k;
    endfunction

    function automatic logic [47:0] sk_hex(input logic [48:1] s);
        logic [47:0] h;
        for (int n = 1; n <= 48; n++) h[48-n] = s[n];
        return h;
    endfunction

    function automatic logic par_err(input logic [63:0] kh);
        logic e = 1'b0;
        for (int b = 0; b < 8; b++) if (^kh[8*b +: 8] == 1'b0) e = 1'b1;
        return e;
    endfunction

    // Halves held as 28-bit integers with FIPS bit 1 as the MSB.
    task automatic compute_model(input logic [63:0] kh);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = kh[64-PC1_T[i]];
            d[27-i] = kh[64-PC1_T[28+i]];
        end
        for (int r = 0; r < 16; r++) begin
            c = (c << SH[r]) | (c >> (28 - SH[r]));
            d = (d << SH[r]) | (d >> (28 - SH[r]));
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2_T[j]];
            model_ks[r] = k;
        end
    endtask

    task automatic run_sched(input logic [63:0] kh, input bit dec, input int stall_at,
                             input int stall_len, input int poke_at, input int rst_at,
                             input bit chk_lat);
        int xfers = 0;
        int cyc = 0;
        int stalled = 0;
        int idx;
        bit poked = 0;
        bit got_done = 0;
        compute_model(kh);
        key = to_key(kh);
        decrypt = dec;
        start = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", valid, 0);
        chk("parity_flag", perr, par_err(kh));
        chk("parity_flag_off", perr0, 0);
        while (cyc < 120) begin
            if (done) begin
                got_done = 1;
                break;
            end
            start = 1'b0;
            subkey_ready = 1'b1;
            if (valid) begin
                idx = dec ? 15 - xfers : xfers;
                chk("subkey", sk_hex(subkey), model_ks[idx]);
                chk("round", rnd, idx);
                if (xfers == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_valid", valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_subkey", sk_hex(subkey), 0);
                    chk("rst_round", rnd, 0);
                    repeat (4) begin
                        chk("rst_no_done", done, 0);
                        @(negedge clk);
                    end
                    return;
                end
                if (xfers == stall_at && stalled < stall_len) begin
                    subkey_ready = 1'b0;
                    stalled++;
                end else begin
                    chk("subkey_nopar", sk_hex(subkey0), model_ks[idx]);
                    cap[idx] = sk_hex(subkey);
                    xfers++;
                end
                if (xfers == poke_at && !poked) begin
                    start = 1'b1;
                    key = to_key(~kh);
                    decrypt = ~dec;
                    poked = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", got_done, 1);
        chk("xfer_count", xfers, 16);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", valid, 0);
        if (chk_lat) chk("latency", cyc - 1, 17);
    endtask

    vec_t vt [8];

    initial begin
        vt[0] = '{KEY_A, 1'b0, 0,  48'h1B02EFFC7072};
        vt[1] = '{KEY_A, 1'b0, 1,  48'h79AED9DBC9E5};
        vt[2] = '{KEY_A, 1'b0, 15, 48'hCB3D8B0E17F5};
        vt[3] = '{KEY_A, 1'b1, 15, 48'hCB3D8B0E17F5};
        vt[4] = '{KEY_A, 1'b1, 0,  48'h1B02EFFC7072};
        vt[5] = '{KEY_Z, 1'b0, 0,  48'h0};
        vt[6] = '{KEY_Z, 1'b1, 7,  48'h0};
        vt[7] = '{KEY_Z, 1'b0, 15, 48'h0};

        rst = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        subkey_ready = 1'b0;
        key = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_done", done, 0);
        chk("reset_perr", perr, 0);
        chk("reset_subkey", sk_hex(subkey), 0);
        chk("reset_round", rnd, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_sched(vt[i].kh, vt[i].dec, -1, 0, -1, -1, 1'b1);
            chk($sformatf("vector%0d", i), cap[vt[i].idx], vt[i].exp);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        run_sched(KEY_A, 1'b0, 2, 5, -1, -1, 1'b0);
        run_sched(KEY_A, 1'b0, -1, 0, 6, -1, 1'b0);
        run_sched(KEY_A, 1'b1, -1, 0, -1, -1, 1'b1);
        chk("start_on_done_last", cap[0], 48'h1B02EFFC7072);

        run_sched(KEY_A, 1'b0, -1, 0, -1, 8, 1'b0);
        run_sched(KEY_A, 1'b0, -1, 0, -1, -1, 1'b1);
        chk("k1_after_rst", cap[0], 48'h1B02EFFC7072);

        run_sched(KEY_A ^ 64'h1, 1'b0, -1, 0, -1, -1, 1'b1);
        chk("perr_flip_held", perr, 1);
        chk("perr_flip_off", perr0, 0);
        chk("flip_k1", cap[0], 48'h1B02EFFC7072);
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), -1, -1, 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
